pixel_gen_pipe: RTL

//  Pipelined, parametrised successor to the combinational pixel generator.

---
 rtl/pixel_gen_pipe.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pixel_gen_pipe.sv
// Pipelined pixel generator: basketball, rim, backboard and pole over black.
// Output is registered with a fixed two-cycle latency from pixel inputs.
module pixel_gen_pipe #(
  parameter int unsigned COORD_W      = 10,
  parameter int unsigned RGB_W        = 12,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned BALL_R       = 8,
  parameter int unsigned BALL_X0      = 320,
  parameter int unsigned BALL_Y0      = 240,
  parameter int unsigned HOOP_Y       = 256,
  parameter int unsigned RIM_X        = 600,
  parameter int unsigned RIM_W        = 24,
  parameter int unsigned BOARD_X      = 624,
  parameter int unsigned POLE_X       = 628,
  parameter int unsigned POLE_W       = 8,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  input  logic               video_on,
  input  logic               frame_tick,
  input  logic [COORD_W-1:0] ball_x,
  input  logic [COORD_W-1:0] ball_y,
  input  logic               score_pulse,
  output logic [RGB_W-1:0]   rgb_out,
  output logic               video_on_out
);

  localparam int unsigned SQ_W = 2 * COORD_W + 2;
  localparam int unsigned FC_W = $clog2(FLASH_FRAMES + 1);

  // Region bounds, all inclusive
  localparam logic [COORD_W-1:0] RIM_X_LO  = COORD_W'(RIM_X);
  localparam logic [COORD_W-1:0] RIM_X_HI  = COORD_W'(RIM_X + RIM_W - 1);
  localparam logic [COORD_W-1:0] RIM_Y_LO  = COORD_W'(HOOP_Y);
  localparam logic [COORD_W-1:0] RIM_Y_HI  = COORD_W'(HOOP_Y + 3);
  localparam logic [COORD_W-1:0] BRD_X_LO  = COORD_W'(BOARD_X);
  localparam logic [COORD_W-1:0] BRD_X_HI  = COORD_W'(BOARD_X + 3);
  localparam logic [COORD_W-1:0] BRD_Y_LO  = COORD_W'(HOOP_Y - 40);
  localparam logic [COORD_W-1:0] BRD_Y_HI  = COORD_W'(HOOP_Y + 8);
  localparam logic [COORD_W-1:0] POLE_X_LO = COORD_W'(POLE_X);
  localparam logic [COORD_W-1:0] POLE_X_HI = COORD_W'(POLE_X + POLE_W - 1);
  localparam logic [COORD_W-1:0] POLE_Y_LO = COORD_W'(HOOP_Y);
  localparam logic [COORD_W-1:0] POLE_Y_HI = COORD_W'(V_RES - 1);

  localparam logic [SQ_W-1:0] R_SQ = SQ_W'(BALL_R * BALL_R);
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLASH_FRAMES);

  localparam logic [RGB_W-1:0] C_BALL  = RGB_W'(12'hF80);
  localparam logic [RGB_W-1:0] C_RIM   = RGB_W'(12'hF00);
  localparam logic [RGB_W-1:0] C_FLASH = RGB_W'(12'hFF0);
  localparam logic [RGB_W-1:0] C_BOARD = RGB_W'(12'hFFF);
  localparam logic [RGB_W-1:0] C_POLE  = RGB_W'(12'hAAA);
  localparam logic [RGB_W-1:0] C_BG    = '0;

  logic [COORD_W-1:0]        act_x, act_y;
  logic [FC_W-1:0]           flash_cnt;

  logic [COORD_W-1:0]        s1_x, s1_y;
  logic                      s1_von;
  logic signed [COORD_W:0]   s1_dx, s1_dy;

  logic signed [SQ_W-1:0]    dx_ext, dy_ext;
  logic [SQ_W-1:0]           dx_sq, dy_sq;
  logic                      hit_ball, hit_rim, hit_board, hit_pole;
  logic [RGB_W-1:0]          rgb_next;

  // Active ball position: only updated on the frame tick so a frame never tears
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_x <= COORD_W'(BALL_X0);
      act_y <= COORD_W'(BALL_Y0);
    end else if (frame_tick) begin
      act_x <= ball_x;
      act_y <= ball_y;
    end
  end

  // Rim flash counter: score loads (beats a same-cycle tick), tick decrements to 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt <= '0;
    end else if (score_pulse) begin
      flash_cnt <= FC_LOAD;
    end else if (frame_tick && (flash_cnt != '0)) begin
      flash_cnt <= flash_cnt - 1'b1;
    end
  end

  // Stage 1: capture pixel and signed offsets from the ball centre (one extra bit, no wrap)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_x   <= '0;
      s1_y   <= '0;
      s1_von <= 1'b0;
      s1_dx  <= '0;
      s1_dy  <= '0;
    end else begin
      s1_x   <= pixel_x;
      s1_y   <= pixel_y;
      s1_von <= video_on;
      s1_dx  <= $signed({1'b0, pixel_x}) - $signed({1'b0, act_x});
      s1_dy  <= $signed({1'b0, pixel_y}) - $signed({1'b0, act_y});
    end
  end

  // Stage 2 combinational: circle test, region tests and priority colour select
  always_comb begin
    dx_ext    = SQ_W'(s1_dx);
    dy_ext    = SQ_W'(s1_dy);
    dx_sq     = dx_ext * dx_ext;
    dy_sq     = dy_ext * dy_ext;
    hit_ball  = (dx_sq + dy_sq) <= R_SQ;
    hit_rim   = (s1_x >= RIM_X_LO)  && (s1_x <= RIM_X_HI)  &&
                (s1_y >= RIM_Y_LO)  && (s1_y <= RIM_Y_HI);
    hit_board = (s1_x >= BRD_X_LO)  && (s1_x <= BRD_X_HI)  &&
                (s1_y >= BRD_Y_LO)  && (s1_y <= BRD_Y_HI);
    hit_pole  = (s1_x >= POLE_X_LO) && (s1_x <= POLE_X_HI) &&
                (s1_y >= POLE_Y_LO) && (s1_y <= POLE_Y_HI);
    rgb_next  = C_BG;
    if (!s1_von)        rgb_next = C_BG;
    else if (hit_ball)  rgb_next = C_BALL;
    else if (hit_rim)   rgb_next = flash_cnt[0] ? C_FLASH : C_RIM;
    else if (hit_board) rgb_next = C_BOARD;
    else if (hit_pole)  rgb_next = C_POLE;
  end

  // Stage 2 register: colour and delayed video_on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_out      <= '0;
      video_on_out <= 1'b0;
    end else begin
      rgb_out      <= rgb_next;
      video_on_out <= s1_von;
    end
  end

endmodule
